// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, iteration count.
package mips_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

endpackage

// File: rtl/ex_muldiv_if.sv
// Handshake and result bundle between the EX stage controls and the multiply/divide unit.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
`ifdef MULDIV_DIV_EN
  input  logic               div_mode,
`endif
  output logic [2*WIDTH-1:0] acc_next
);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;

  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign mul_next = {sum, acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  // Divide: acc = {partial remainder, dividend/quotient bits}, shifting left.
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_new;

  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge       = rem_sh >= {1'b0, opnd};
  assign rem_new  = ge ? WIDTH'(rem_sh - {1'b0, opnd}) : rem_sh[WIDTH-1:0];
  assign acc_next = div_mode ? {rem_new, acc[WIDTH-2:0], ge} : mul_next;
`else
  assign acc_next = mul_next;
`endif

endmodule

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit writing HI/LO after 32 steps plus a sign-fix cycle.
// MULDIV_DIV_EN enables DIV/DIVU; without it divide starts are ignored.
module ex_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  ex_muldiv_if.slave bus
);

  localparam logic [5:0] LAST = 6'(ITER - 1);

  state_t             state_reg, state_next;
  logic [5:0]         cnt_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_step, prod;
  logic [WIDTH-1:0]   opnd_reg, hi_reg, lo_reg, hi_next, lo_next;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               sa_reg, sb_reg, busy_reg, done_reg;
  logic               sa, sb, is_div, is_signed, accept;
  logic               load, step_en, write_en;

  assign is_div    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign sa        = is_signed & bus.src_a[WIDTH-1];
  assign sb        = is_signed & bus.src_b[WIDTH-1];
  assign a_mag     = sa ? -bus.src_a : bus.src_a;
  assign b_mag     = sb ? -bus.src_b : bus.src_b;

`ifdef MULDIV_DIV_EN
  logic             div_reg, bzero_reg;
  logic [WIDTH-1:0] quo, rem;

  assign accept = 1'b1;
  assign quo    = acc_reg[WIDTH-1:0];
  assign rem    = acc_reg[2*WIDTH-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .opnd     (opnd_reg),
    .div_mode (div_reg),
    .acc_next (acc_step)
  );
`else
  assign accept = !is_div;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .opnd     (opnd_reg),
    .acc_next (acc_step)
  );
`endif

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step_en    = 1'b0;
    write_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.flush && accept) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt_reg == LAST) state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        write_en   = !bus.flush;
      end
      default: state_next = IDLE;
    endcase
  end

  // Division by zero leaves an all-ones quotient, so its sign is never applied.
  always_comb begin
    prod               = (sa_reg ^ sb_reg) ? -acc_reg : acc_reg;
    {hi_next, lo_next} = prod;
`ifdef MULDIV_DIV_EN
    if (div_reg) begin
      lo_next = ((sa_reg ^ sb_reg) && !bzero_reg) ? -quo : quo;
      hi_next = sa_reg ? -rem : rem;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      opnd_reg  <= '0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_reg   <= 1'b0;
      bzero_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= write_en;
      if (load) begin
        cnt_reg   <= '0;
        acc_reg   <= {{WIDTH{1'b0}}, a_mag};
        opnd_reg  <= b_mag;
        sa_reg    <= sa;
        sb_reg    <= sb;
`ifdef MULDIV_DIV_EN
        div_reg   <= is_div;
        bzero_reg <= (bus.src_b == '0);
`endif
      end else if (step_en) begin
        acc_reg <= acc_step;
        cnt_reg <= cnt_reg + 6'd1;
      end
      if (write_en) begin
        hi_reg <= hi_next;
        lo_reg <= lo_next;
      end
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random ops against an arithmetic model.
// Divide expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv;
  import mips_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(32)) bus ();

  ex_muldiv #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] a64, b64, p64;
    logic signed [31:0] q, r;
    a64 = $signed(a);
    b64 = $signed(b);
    case (op)
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_MULT: begin
        p64 = a64 * b64;
        return p64;
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op in cycle N and check the whole N+1..N+34 window.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit          acc, busy_ok, done_ok, hold_ok;
    logic [63:0] r;
    acc = DIV_EN || !op[1];
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    busy_ok = 1'b1;
    done_ok = 1'b1;
    hold_ok = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      if (bus.busy !== acc) busy_ok = 1'b0;
      if (bus.done !== 1'b0) done_ok = 1'b0;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) hold_ok = 1'b0;
      tick();
    end
    check("busy_window", 64'(busy_ok), 64'd1);
    check("no_early_done", 64'(done_ok), 64'd1);
    check("hilo_hold", 64'(hold_ok), 64'd1);
    if (acc) begin
      r      = model(op, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    check("done_pulse", 64'(bus.done), 64'(acc));
    check("busy_end", 64'(bus.busy), 64'd0);
    check("hi", 64'(bus.hi), 64'(exp_hi));
    check("lo", 64'(bus.lo), 64'(exp_lo));
    $display("[TB] op=%0d a=%h b=%h accepted=%0d -> hi=%h lo=%h", op, a, b, acc, bus.hi, bus.lo);
  endtask

  initial begin
    bit ok;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFF1);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
`ifdef MULDIV_DIV_EN
    check("div_neg_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    check("div_neg_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
`endif
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd5, 32'd0);
`ifdef MULDIV_DIV_EN
    check("divu_zero_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
    check("divu_zero_hi", 64'(bus.hi), 64'h0000_0000_0000_0005);
`endif
    run_op(OP_DIVU, 32'd8, 32'd2);
    run_op(OP_MULT, 32'h0000_0007, 32'hFFFF_FFF0);

    // flush outranks start while idle
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd9;
    bus.src_b = 32'd9;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_prio_busy", 64'(bus.busy), 64'd0);
    tick();
    check("flush_prio_busy2", 64'(bus.busy), 64'd0);

    // flush during RUN in cycle N+10
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd3;
    bus.src_b = 32'd4;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
      tick();
    end
    check("flush_no_done", 64'(ok), 64'd1);
    check("flush_hi", 64'(bus.hi), 64'(exp_hi));
    check("flush_lo", 64'(bus.lo), 64'(exp_lo));
    $display("[TB] flush at N+10 -> busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    // reset during RUN in cycle N+10
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd3;
    bus.src_b = 32'd4;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    tick();
    rst    = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    tick();
    check("arst_hi", 64'(bus.hi), 64'd0);
    check("arst_lo", 64'(bus.lo), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    $display("[TB] reset at N+10 -> hi=%h lo=%h", bus.hi, bus.lo);

    // second start in N+5 while busy must be dropped
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd7;
    bus.src_b = 32'd9;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.src_a = 32'hFFFF_0000;
    bus.src_b = 32'd123;
    tick();
    bus.start = 1'b0;
    repeat (28) tick();
    exp_hi = 32'd0;
    exp_lo = 32'd63;
    check("busy_start_done", 64'(bus.done), 64'd1);
    check("busy_start_hi", 64'(bus.hi), 64'(exp_hi));
    check("busy_start_lo", 64'(bus.lo), 64'(exp_lo));
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) ok = 1'b0;
    end
    check("busy_start_dropped", 64'(ok), 64'd1);
    $display("[TB] start while busy -> hi=%h lo=%h", bus.hi, bus.lo);

    // random back-to-back ops, each new start lands in the previous done cycle
    for (int i = 0; i < 16; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
